// File: rtl/dsp48_defs.sv
// Shared DSP48E1 slice definitions: SIMD lane encodings, ALUMODE codes, lane widths,
// and the per-lane carry function used by the post-adder carry-out generator.
package dsp48_defs;

  typedef enum logic [1:0] {
    SIMD_ONE48  = 2'b00,
    SIMD_TWO24  = 2'b01,
    SIMD_FOUR12 = 2'b10
  } simd_e;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_ADD_NZ  = 4'b0001;
  localparam logic [3:0] ALU_NOT_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0011;

  localparam int LANE_W_FOUR12 = 12;
  localparam int LANE_W_TWO24  = 24;
  localparam int LANE_W_ONE48  = 48;

  // Operands arrive right-aligned; everything above bit w-1 is masked away so one
  // 50-bit datapath serves every lane width without leaking bits from other lanes.
  function automatic logic lane_carry(input int w,
                                      input logic [47:0] x,
                                      input logic [47:0] y,
                                      input logic [47:0] z,
                                      input logic cin,
                                      input logic [3:0] op);
    logic [49:0] mask;
    logic [49:0] xs;
    logic [49:0] ys;
    logic [49:0] zs;
    logic [49:0] zi;
    logic [49:0] ci;
    logic [49:0] s;
    logic        c;
    mask = (50'd1 << w) - 50'd1;
    xs   = {2'b00, x} & mask;
    ys   = {2'b00, y} & mask;
    zs   = {2'b00, z} & mask;
    zi   = (~{2'b00, z}) & mask;
    ci   = {49'd0, cin};
    s    = '0;
    c    = 1'b0;
    case (op)
      ALU_ADD, ALU_NOT_ADD: begin
        s = zs + xs + ys + ci;
        c = |(s >> w);
      end
      ALU_ADD_NZ: begin
        s = zi + xs + ys + ci;
        c = |(s >> w);
      end
      ALU_SUB: c = (zs >= (xs + ys + ci));
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/logic_ports.sv
// Optional pipeline register with clock enable: sel=1 returns the registered value,
// sel=0 bypasses the register so the data path is purely combinational.
module logic_ports #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         sel,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = ce ? d : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = sel ? data_q : d;

endmodule

// File: rtl/carry_out_gen.sv
// DSP48E1 post-adder carry-out generator: per-lane CARRYOUT and CARRYCASCOUT from
// X/Y/Z/CIN under the selected ALUMODE and SIMD split, with optional in/out registers.
module carry_out_gen
  import dsp48_defs::*;
#(
  parameter int P_W = 48
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           CEP,
  input  logic           CEALUMODE,
  input  logic           CARRYOUTREG,
  input  logic           ALUMODEREG,
  input  logic [1:0]     USE_SIMD,
  input  logic [3:0]     ALUMODE,
  input  logic [P_W-1:0] X,
  input  logic [P_W-1:0] Y,
  input  logic [P_W-1:0] Z,
  input  logic           CIN,
  output logic [3:0]     CARRYOUT,
  output logic           CARRYCASCOUT
);

  logic [3:0] aluMode;
  logic [3:0] carryRaw;
  logic [1:0] topPath;

  logic_ports #(.W(4)) uAluModeReg (
    .clk (clk),
    .rst (rst),
    .ce  (CEALUMODE),
    .sel (ALUMODEREG),
    .d   (ALUMODE),
    .q   (aluMode)
  );

  // CIN feeds only the lowest lane of each split; upper lanes always start from 0.
  always_comb begin
    carryRaw = '0;
    case (USE_SIMD)
      SIMD_FOUR12: begin
        carryRaw[0] = lane_carry(LANE_W_FOUR12, X, Y, Z, CIN, aluMode);
        carryRaw[1] = lane_carry(LANE_W_FOUR12, X >> 12, Y >> 12, Z >> 12, 1'b0, aluMode);
        carryRaw[2] = lane_carry(LANE_W_FOUR12, X >> 24, Y >> 24, Z >> 24, 1'b0, aluMode);
        carryRaw[3] = lane_carry(LANE_W_FOUR12, X >> 36, Y >> 36, Z >> 36, 1'b0, aluMode);
      end
      SIMD_TWO24: begin
        carryRaw[1] = lane_carry(LANE_W_TWO24, X, Y, Z, CIN, aluMode);
        carryRaw[3] = lane_carry(LANE_W_TWO24, X >> 24, Y >> 24, Z >> 24, 1'b0, aluMode);
      end
      default: begin
        carryRaw[3] = lane_carry(LANE_W_ONE48, X, Y, Z, CIN, aluMode);
      end
    endcase
  end

  logic_ports #(.W(3)) uCarryLowReg (
    .clk (clk),
    .rst (rst),
    .ce  (CEP),
    .sel (CARRYOUTREG),
    .d   (carryRaw[2:0]),
    .q   (CARRYOUT[2:0])
  );

  // The cascade carry rides the same register as CARRYOUT[3] so the two never skew.
  logic_ports #(.W(2)) uCarryTopReg (
    .clk (clk),
    .rst (rst),
    .ce  (CEP),
    .sel (CARRYOUTREG),
    .d   ({carryRaw[3], carryRaw[3]}),
    .q   (topPath)
  );

  assign CARRYOUT[3]  = topPath[1];
  assign CARRYCASCOUT = topPath[0];

endmodule

// File: tb/tb_carry_out_gen.sv
// Directed self-checking bench for carry_out_gen: combinational lane carries,
// output/ALUMODE register timing, clock enables and asynchronous reset.
module tb_carry_out_gen;

  logic        clk;
  logic        rst;
  logic        CEP;
  logic        CEALUMODE;
  logic        CARRYOUTREG;
  logic        ALUMODEREG;
  logic [1:0]  USE_SIMD;
  logic [3:0]  ALUMODE;
  logic [47:0] X;
  logic [47:0] Y;
  logic [47:0] Z;
  logic        CIN;
  logic [3:0]  CARRYOUT;
  logic        CARRYCASCOUT;

  int vectorCount;
  int miscompareCount;

  localparam logic [47:0] ALL_ONES = 48'hFFFF_FFFF_FFFF;

  carry_out_gen #(.P_W(48)) dut (
    .clk          (clk),
    .rst          (rst),
    .CEP          (CEP),
    .CEALUMODE    (CEALUMODE),
    .CARRYOUTREG  (CARRYOUTREG),
    .ALUMODEREG   (ALUMODEREG),
    .USE_SIMD     (USE_SIMD),
    .ALUMODE      (ALUMODE),
    .X            (X),
    .Y            (Y),
    .Z            (Z),
    .CIN          (CIN),
    .CARRYOUT     (CARRYOUT),
    .CARRYCASCOUT (CARRYCASCOUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] simd, input logic [3:0] op,
                               input logic [47:0] xv, input logic [47:0] yv,
                               input logic [47:0] zv, input logic cinv);
    USE_SIMD = simd;
    ALUMODE  = op;
    X        = xv;
    Y        = yv;
    Z        = zv;
    CIN      = cinv;
  endtask

  // Expected value packs {CARRYOUT, CARRYCASCOUT}.
  task automatic checkOutput(input string tag, input logic [4:0] expected);
    logic [4:0] observed;
    observed = {CARRYOUT, CARRYCASCOUT};
    vectorCount++;
    assert (observed === expected)
    else begin
      miscompareCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    vectorCount     = 0;
    miscompareCount = 0;
    rst         = 1'b1;
    CEP         = 1'b1;
    CEALUMODE   = 1'b1;
    CARRYOUTREG = 1'b1;
    ALUMODEREG  = 1'b1;
    applyStimulus(2'b00, 4'b0000, ALL_ONES, 48'd0, 48'd0, 1'b1);

    @(posedge clk);
    #1 checkOutput("reset_regs", 5'b0000_0);
    @(negedge clk);
    rst = 1'b0;

    CARRYOUTREG = 1'b0;
    ALUMODEREG  = 1'b0;
    CEP         = 1'b0;

    applyStimulus(2'b00, 4'b0000, ALL_ONES, 48'd0, 48'd0, 1'b1);
    #1 checkOutput("one48_add_cin1", 5'b1000_1);
    applyStimulus(2'b00, 4'b0000, ALL_ONES, 48'd0, 48'd0, 1'b0);
    #1 checkOutput("one48_add_cin0", 5'b0000_0);
    applyStimulus(2'b10, 4'b0000, ALL_ONES, 48'd0, 48'd0, 1'b1);
    #1 checkOutput("four12_cin_lane0", 5'b0001_0);
    applyStimulus(2'b01, 4'b0000, ALL_ONES, 48'd0, 48'd0, 1'b1);
    #1 checkOutput("two24_cin_lane0", 5'b0010_0);
    applyStimulus(2'b11, 4'b0000, ALL_ONES, 48'd0, 48'd0, 1'b1);
    #1 checkOutput("simd11_as_one48", 5'b1000_1);
    applyStimulus(2'b00, 4'b0010, ALL_ONES, 48'd0, 48'd0, 1'b1);
    #1 checkOutput("one48_notadd", 5'b1000_1);
    applyStimulus(2'b00, 4'b0001, 48'd1, 48'd0, 48'd0, 1'b0);
    #1 checkOutput("one48_invz_carry", 5'b1000_1);
    applyStimulus(2'b00, 4'b0001, 48'd0, 48'd0, 48'd0, 1'b0);
    #1 checkOutput("one48_invz_nocarry", 5'b0000_0);
    applyStimulus(2'b10, 4'b0000, ALL_ONES, ALL_ONES, ALL_ONES, 1'b0);
    #1 checkOutput("four12_triple_ovf", 5'b1111_1);
    applyStimulus(2'b00, 4'b0011, 48'd3, 48'd0, 48'd5, 1'b0);
    #1 checkOutput("sub_z5_x3", 5'b1000_1);
    applyStimulus(2'b00, 4'b0011, 48'd5, 48'd0, 48'd3, 1'b0);
    #1 checkOutput("sub_z3_x5", 5'b0000_0);
    applyStimulus(2'b00, 4'b0011, 48'd5, 48'd0, 48'd5, 1'b0);
    #1 checkOutput("sub_equal", 5'b1000_1);
    applyStimulus(2'b00, 4'b0011, 48'd5, 48'd0, 48'd5, 1'b1);
    #1 checkOutput("sub_equal_cin", 5'b0000_0);
    applyStimulus(2'b10, 4'b0011, 48'd0, 48'd0, 48'd0, 1'b0);
    #1 checkOutput("four12_sub_zero", 5'b1111_1);
    applyStimulus(2'b00, 4'b0100, ALL_ONES, 48'd0, 48'd0, 1'b1);
    #1 checkOutput("logic_op_zero", 5'b0000_0);

    // Output register path
    @(negedge clk);
    CARRYOUTREG = 1'b1;
    applyStimulus(2'b00, 4'b0000, ALL_ONES, 48'd0, 48'd0, 1'b1);
    #1 checkOutput("reg_before_edge", 5'b0000_0);
    @(negedge clk);
    CEP = 1'b1;
    @(posedge clk);
    #1 checkOutput("reg_after_edge", 5'b1000_1);
    @(negedge clk);
    CEP = 1'b0;
    applyStimulus(2'b00, 4'b0000, 48'd0, 48'd0, 48'd0, 1'b0);
    @(posedge clk);
    #1 checkOutput("reg_hold_cep0", 5'b1000_1);
    @(negedge clk);
    CEP = 1'b1;
    @(posedge clk);
    #1 checkOutput("reg_reload_cep1", 5'b0000_0);

    // Asynchronous reset between edges
    @(negedge clk);
    applyStimulus(2'b00, 4'b0000, ALL_ONES, 48'd0, 48'd0, 1'b1);
    @(posedge clk);
    #1 checkOutput("reg_set_before_rst", 5'b1000_1);
    #2 rst = 1'b1;
    #1 checkOutput("async_rst_clear", 5'b0000_0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 checkOutput("post_rst_reload", 5'b1000_1);

    // ALUMODE register path
    @(negedge clk);
    CARRYOUTREG = 1'b0;
    ALUMODEREG  = 1'b1;
    CEALUMODE   = 1'b1;
    applyStimulus(2'b00, 4'b0000, 48'd0, 48'd0, 48'd0, 1'b0);
    @(posedge clk);
    #1 checkOutput("alureg_add", 5'b0000_0);
    @(negedge clk);
    ALUMODE = 4'b0011;
    #1 checkOutput("alureg_not_yet", 5'b0000_0);
    @(posedge clk);
    #1 checkOutput("alureg_sub_loaded", 5'b1000_1);
    @(negedge clk);
    CEALUMODE = 1'b0;
    ALUMODE   = 4'b0000;
    @(posedge clk);
    #1 checkOutput("alureg_ce_blocks", 5'b1000_1);
    @(negedge clk);
    CEALUMODE = 1'b1;
    @(posedge clk);
    #1 checkOutput("alureg_ce_reopen", 5'b0000_0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
